hazard_stall_ctrl: RTL and testbench

- Pipeline hazard and stall sequencer for the 5-stage RV32I core.
- Drives the bubble (hold) and flush (clear) inputs of every IF/ID/EX/MEM/WB segment register, including the EX/MEM control segment register.
- Resolves load-use hazards, taken branches and jumps, and multi-cycle data-cache misses through a small FSM.
- Keeps a miss-stall performance counter and a watchdog that flags stuck misses.

---
 rtl/hazard_stall_ctrl.sv | 132 +++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall sequencer: bubble (hold) and flush (clear) for IF/ID/EX/MEM/WB segments.
// Latency: bubble/flush are combinational from state and inputs; state and counters are registered.
// Backpressure: a data-cache miss holds IF..MEM and drains WB until cache_done; other hazards never stall >1 cycle.
module hazard_stall_ctrl #(
  parameter int MISS_TIMEOUT = 1023,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             rs1_used_ID,
  input  logic             rs2_used_ID,
  input  logic [4:0]       rd_EX,
  input  logic             reg_write_en_EX,
  input  logic             wb_select_EX,
  input  logic             br_taken_EX,
  input  logic             jalr_EX,
  input  logic             jal_ID,
  input  logic             cache_miss,
  input  logic             cache_done,
  output logic             bubbleF,
  output logic             bubbleD,
  output logic             bubbleE,
  output logic             bubbleM,
  output logic             bubbleW,
  output logic             flushF,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             flushW,
  output logic [CNT_W-1:0] miss_stall_cycles,
  output logic             timeout_err
);

  // Wide enough to hold MISS_TIMEOUT; saturates at all-ones, which is >= MISS_TIMEOUT.
  localparam int WAIT_W = (MISS_TIMEOUT < 2) ? 1 : $clog2(MISS_TIMEOUT + 1);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;

  // A load in EX whose destination is read by the instruction in ID cannot be forwarded in time.
  always_comb begin
    load_use = wb_select_EX & reg_write_en_EX & (rd_EX != 5'd0) &
               ((rs1_used_ID & (rd_EX == rs1_ID)) | (rs2_used_ID & (rd_EX == rs2_ID)));
  end

  // Next state and prioritised bubble/flush decode; reset forces a full pipeline clear.
  always_comb begin
    state_nxt = state;
    bubbleF   = 1'b0;
    bubbleD   = 1'b0;
    bubbleE   = 1'b0;
    bubbleM   = 1'b0;
    bubbleW   = 1'b0;
    flushF    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    flushM    = 1'b0;
    flushW    = 1'b0;
    if (rst) begin
      flushF = 1'b1;
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
      flushW = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (cache_miss) begin
            // Control hazards seen this cycle stay in their held stages and are re-seen later.
            bubbleF   = 1'b1;
            bubbleD   = 1'b1;
            bubbleE   = 1'b1;
            bubbleM   = 1'b1;
            flushW    = 1'b1;
            state_nxt = MEM_WAIT;
          end else if (br_taken_EX || jalr_EX) begin
            flushD = 1'b1;
            flushE = 1'b1;
          end else if (load_use) begin
            bubbleF = 1'b1;
            bubbleD = 1'b1;
            flushE  = 1'b1;
          end else if (jal_ID) begin
            flushD = 1'b1;
          end
        end
        MEM_WAIT: begin
          // The done cycle still stalls; the MEM instruction advances on the following edge.
          bubbleF = 1'b1;
          bubbleD = 1'b1;
          bubbleE = 1'b1;
          bubbleM = 1'b1;
          flushW  = 1'b1;
          if (cache_done) state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Miss wait counter, saturating stall counter and sticky watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt          <= '0;
      miss_stall_cycles <= '0;
      timeout_err       <= 1'b0;
    end else begin
      if (state == RUN) begin
        if (cache_miss) wait_cnt <= WAIT_W'(1);
      end else begin
        if (wait_cnt != {WAIT_W{1'b1}})          wait_cnt <= wait_cnt + 1'b1;
        if (miss_stall_cycles != {CNT_W{1'b1}}) miss_stall_cycles <= miss_stall_cycles + 1'b1;
        if (wait_cnt >= WAIT_W'(MISS_TIMEOUT))   timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: vector table for RUN-state decode, sequences for miss/reset.
// Outputs are sampled #1 after inputs change at the falling edge, registers after the rising edge.
// Small MISS_TIMEOUT and CNT_W so the watchdog and counter saturation are reachable quickly.
module tb_hazard_stall_ctrl;

  localparam int TO = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    rs1_ID, rs2_ID, rd_EX;
  logic          rs1_used_ID, rs2_used_ID, reg_write_en_EX, wb_select_EX;
  logic          br_taken_EX, jalr_EX, jal_ID, cache_miss, cache_done;
  logic          bubbleF, bubbleD, bubbleE, bubbleM, bubbleW;
  logic          flushF, flushD, flushE, flushM, flushW;
  logic [CW-1:0] miss_stall_cycles;
  logic          timeout_err;
  logic [9:0]    outs;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MISS_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
    .rd_EX(rd_EX), .reg_write_en_EX(reg_write_en_EX), .wb_select_EX(wb_select_EX),
    .br_taken_EX(br_taken_EX), .jalr_EX(jalr_EX), .jal_ID(jal_ID),
    .cache_miss(cache_miss), .cache_done(cache_done),
    .bubbleF(bubbleF), .bubbleD(bubbleD), .bubbleE(bubbleE), .bubbleM(bubbleM), .bubbleW(bubbleW),
    .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .miss_stall_cycles(miss_stall_cycles), .timeout_err(timeout_err)
  );

  assign outs = {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW, flushF, flushD, flushE, flushM, flushW};

  // Expected output patterns {bubbleF..W, flushF..W}.
  localparam logic [9:0] O_NONE  = 10'b00000_00000;
  localparam logic [9:0] O_LU    = 10'b11000_00100;
  localparam logic [9:0] O_BR    = 10'b00000_01100;
  localparam logic [9:0] O_JAL   = 10'b00000_01000;
  localparam logic [9:0] O_STALL = 10'b11110_00001;
  localparam logic [9:0] O_RST   = 10'b00000_11111;

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, we, wbs, br, jalr, jal;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rs1_ID = 0; rs2_ID = 0; rd_EX = 0;
    rs1_used_ID = 0; rs2_used_ID = 0; reg_write_en_EX = 0; wb_select_EX = 0;
    br_taken_EX = 0; jalr_EX = 0; jal_ID = 0; cache_miss = 0; cache_done = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //                name          rs1 rs2 rd  u1 u2 we wbs br jalr jal exp
    vecs[0]  = '{"idle",          0,  0,  0,  0, 0, 0, 0,  0, 0,   0,  O_NONE};
    vecs[1]  = '{"lu_rs2",        0,  5,  5,  0, 1, 1, 1,  0, 0,   0,  O_LU};
    vecs[2]  = '{"lu_rd0",        0,  0,  0,  0, 1, 1, 1,  0, 0,   0,  O_NONE};
    vecs[3]  = '{"lu_rs1",        7,  3,  7,  1, 1, 1, 1,  0, 0,   0,  O_LU};
    vecs[4]  = '{"rs1_unused",    7,  3,  7,  0, 1, 1, 1,  0, 0,   0,  O_NONE};
    vecs[5]  = '{"no_write",      0,  5,  5,  0, 1, 0, 1,  0, 0,   0,  O_NONE};
    vecs[6]  = '{"alu_not_load",  0,  5,  5,  0, 1, 1, 0,  0, 0,   0,  O_NONE};
    vecs[7]  = '{"br_over_lu",    0,  5,  5,  0, 1, 1, 1,  1, 0,   0,  O_BR};
    vecs[8]  = '{"jalr",          0,  0,  0,  0, 0, 0, 0,  0, 1,   0,  O_BR};
    vecs[9]  = '{"jal",           0,  0,  0,  0, 0, 0, 0,  0, 0,   1,  O_JAL};
    vecs[10] = '{"lu_over_jal",   0,  5,  5,  0, 1, 1, 1,  0, 0,   1,  O_LU};
    vecs[11] = '{"br_over_jal",   0,  0,  0,  0, 0, 0, 0,  1, 0,   1,  O_BR};

    idle_inputs();
    rst = 1'b1;
    #1;
    check("reset_outs", 32'(outs), 32'(O_RST));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_cnt", 32'(miss_stall_cycles), 0);
    check("reset_to", 32'(timeout_err), 0);
    rst = 1'b0;
    #1;
    check("post_reset_outs", 32'(outs), 32'(O_NONE));

    // RUN-state decode table.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rs1_ID = vecs[i].rs1; rs2_ID = vecs[i].rs2; rd_EX = vecs[i].rd;
      rs1_used_ID = vecs[i].u1; rs2_used_ID = vecs[i].u2;
      reg_write_en_EX = vecs[i].we; wb_select_EX = vecs[i].wbs;
      br_taken_EX = vecs[i].br; jalr_EX = vecs[i].jalr; jal_ID = vecs[i].jal;
      #1;
      check(vecs[i].name, 32'(outs), 32'(vecs[i].exp));
    end
    @(negedge clk);
    idle_inputs();
    #1;
    check("lu_one_cycle", 32'(outs), 32'(O_NONE));

    // Miss: entry cycle + 4 MEM_WAIT cycles, done on the 4th.
    @(negedge clk);
    cache_miss = 1'b1;
    #1;
    check("miss_entry", 32'(outs), 32'(O_STALL));
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      cache_miss = 1'b0;
      cache_done = (c == 4);
      #1;
      check($sformatf("miss_wait%0d", c), 32'(outs), 32'(O_STALL));
    end
    @(negedge clk);
    cache_done = 1'b0;
    #1;
    check("miss_back_run", 32'(outs), 32'(O_NONE));
    check("miss_cnt4", 32'(miss_stall_cycles), 4);

    // cache_done in RUN is ignored.
    cache_done = 1'b1;
    @(negedge clk);
    cache_done = 1'b0;
    #1;
    check("done_in_run", 32'(outs), 32'(O_NONE));

    // Miss with a simultaneous taken branch: branch acted on only after return.
    @(negedge clk);
    cache_miss = 1'b1; br_taken_EX = 1'b1;
    #1;
    check("missbr_entry", 32'(outs), 32'(O_STALL));
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      cache_miss = 1'b1;      // ignored in MEM_WAIT
      cache_done = (c == 2);
      #1;
      check($sformatf("missbr_wait%0d", c), 32'(outs), 32'(O_STALL));
    end
    @(negedge clk);
    cache_miss = 1'b0; cache_done = 1'b0;
    #1;
    check("missbr_first_run", 32'(outs), 32'(O_BR));
    check("missbr_cnt6", 32'(miss_stall_cycles), 6);
    @(negedge clk);
    idle_inputs();

    // Watchdog: entry edge, then timeout_err rises on the 8th edge after entry.
    @(negedge clk);
    cache_miss = 1'b1;
    @(negedge clk);          // entry edge done, wait counter = 1
    cache_miss = 1'b0;
    repeat (7) @(negedge clk);
    check("wd_before", 32'(timeout_err), 0);
    @(negedge clk);
    check("wd_rise", 32'(timeout_err), 1);
    repeat (12) @(negedge clk);
    #1;
    check("wd_still_stall", 32'(outs), 32'(O_STALL));
    check("cnt_saturate", 32'(miss_stall_cycles), 15);
    cache_done = 1'b1;
    @(negedge clk);
    cache_done = 1'b0;
    #1;
    check("wd_exit_run", 32'(outs), 32'(O_NONE));
    check("wd_sticky", 32'(timeout_err), 1);
    check("cnt_held", 32'(miss_stall_cycles), 15);

    // Reset in the middle of MEM_WAIT.
    @(negedge clk);
    cache_miss = 1'b1;
    @(negedge clk);
    cache_miss = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("rstmid_stalled", 32'(outs), 32'(O_STALL));
    rst = 1'b1;
    #1;
    check("rstmid_flush", 32'(outs), 32'(O_RST));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstmid_run", 32'(outs), 32'(O_NONE));
    check("rstmid_cnt", 32'(miss_stall_cycles), 0);
    check("rstmid_to", 32'(timeout_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
